// File: rtl/seg7_seq_monitor.sv
// Debounces an active-low 7-segment pattern, decodes it to a digit and checks
// that the accepted digits advance by +1 modulo M, counting steps and errors.
module seg7_seq_monitor #(
  parameter int STABLE_CYC = 4,
  parameter int M          = 10
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        enable,
  input  logic [0:6]  seg,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        illegal,
  output logic        seq_err,
  output logic [15:0] step_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } dec_t;

  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYC);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYC - 1);
  localparam logic [3:0] M_LAST    = 4'(M - 1);
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  function automatic dec_t decode_seg(input logic [0:6] p);
    dec_t d;
    d = '{legal: 1'b1, blank: 1'b0, value: 4'd0};
    case (p)
      7'b0000001: d.value = 4'd0;
      7'b1001111: d.value = 4'd1;
      7'b0010010: d.value = 4'd2;
      7'b0000110: d.value = 4'd3;
      7'b1001100: d.value = 4'd4;
      7'b0100100: d.value = 4'd5;
      7'b0100000: d.value = 4'd6;
      7'b0001111: d.value = 4'd7;
      7'b0000000: d.value = 4'd8;
      7'b0000100: d.value = 4'd9;
      7'b1111111: begin
        d.legal = 1'b0;
        d.blank = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  logic [0:6]  seg_q_r;
  logic [7:0]  stab_cnt_r;
  logic        accept_s;
  dec_t        dec_s;
  logic [3:0]  next_ref_s;
  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  digit_nxt_s;
  logic        digit_valid_nxt_s;
  logic        illegal_nxt_s;
  logic        seq_err_nxt_s;
  logic [15:0] step_cnt_nxt_s;
  logic [7:0]  err_cnt_nxt_s;

  // Stability filter: restart on any change, accept once per stable period.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      seg_q_r    <= SEG_BLANK;
      stab_cnt_r <= STAB_MAX;
    end else if (seg != seg_q_r) begin
      seg_q_r    <= seg;
      stab_cnt_r <= 8'd0;
    end else if (stab_cnt_r < STAB_LAST) begin
      stab_cnt_r <= stab_cnt_r + 8'd1;
    end else if (stab_cnt_r == STAB_LAST) begin
      stab_cnt_r <= STAB_MAX;
    end else begin
      stab_cnt_r <= stab_cnt_r;
    end
  end

  assign accept_s   = (seg == seg_q_r) && (stab_cnt_r == STAB_LAST);
  assign dec_s      = decode_seg(seg_q_r);
  assign next_ref_s = (digit == M_LAST) ? 4'd0 : digit + 4'd1;

  // Next-state and next-output decision for one accepted pattern.
  always_comb begin
    state_nxt_s       = state_r;
    digit_nxt_s       = digit;
    digit_valid_nxt_s = 1'b0;
    illegal_nxt_s     = 1'b0;
    seq_err_nxt_s     = 1'b0;
    step_cnt_nxt_s    = step_cnt;
    err_cnt_nxt_s     = err_cnt;
    if (accept_s && enable) begin
      if (dec_s.blank) begin
        state_nxt_s = S_IDLE;
      end else if (!dec_s.legal) begin
        illegal_nxt_s = 1'b1;
        err_cnt_nxt_s = sat_inc8(err_cnt);
        state_nxt_s   = S_IDLE;
      end else begin
        digit_nxt_s       = dec_s.value;
        digit_valid_nxt_s = 1'b1;
        state_nxt_s       = S_TRACK;
        case (state_r)
          S_IDLE: begin
            step_cnt_nxt_s = step_cnt;
          end
          S_TRACK: begin
            // A reference outside 0..M-1 has no valid successor.
            if (dec_s.value == digit) begin
              step_cnt_nxt_s = step_cnt;
            end else if ((digit <= M_LAST) && (dec_s.value == next_ref_s)) begin
              step_cnt_nxt_s = step_cnt + 16'd1;
            end else begin
              seq_err_nxt_s = 1'b1;
              err_cnt_nxt_s = sat_inc8(err_cnt);
            end
          end
          default: begin
            state_nxt_s = S_IDLE;
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      state_r     <= S_IDLE;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      step_cnt    <= 16'd0;
      err_cnt     <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      digit       <= digit_nxt_s;
      digit_valid <= digit_valid_nxt_s;
      illegal     <= illegal_nxt_s;
      seq_err     <= seq_err_nxt_s;
      step_cnt    <= step_cnt_nxt_s;
      err_cnt     <= err_cnt_nxt_s;
    end
  end

endmodule

// File: doc/seg7_seq_monitor.md
SEG7_SEQ_MONITOR -- requirements
Module: seg7_seq_monitor

Interface
REQ-001 Parameter STABLE_CYC, default 4: number of consecutive cycles a segment pattern must be held before it is accepted; legal range 2..255.
REQ-002 Parameter M, default 10: modulus of the expected digit sequence; legal range 2..10.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 aclr  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  when high, accepted patterns update outputs; when low, accepted patterns are discarded.
REQ-006 seg  input  [0:6]  active-low 7-segment pattern; seg[0]=a through seg[6]=g.
REQ-007 digit  output  4  last accepted legal digit, 0..9.
REQ-008 digit_valid  output  1  one-cycle pulse per accepted legal digit.
REQ-009 illegal  output  1  one-cycle pulse per accepted illegal pattern.
REQ-010 seq_err  output  1  one-cycle pulse per accepted out-of-sequence digit.
REQ-011 step_cnt  output  16  count of correct +1 (mod M) steps; wraps at 65535 to 0.
REQ-012 err_cnt  output  8  count of illegal patterns plus sequence errors; saturates at 255.

Function
REQ-013 Decode table (seg[0:6] to digit): 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
REQ-014 Pattern 1111111 SHALL be classed as blank; every other pattern not in REQ-013 SHALL be classed as illegal.
REQ-015 Stability filter: registers seg_q and stab_cnt (saturating at STABLE_CYC); on any edge where seg != seg_q, seg_q <= seg and stab_cnt <= 0.
REQ-016 When seg == seg_q and stab_cnt < STABLE_CYC-1, stab_cnt SHALL increment.
REQ-017 When seg == seg_q and stab_cnt == STABLE_CYC-1, an accept event SHALL occur and stab_cnt <= STABLE_CYC; at most one accept per stable period.
REQ-018 Latency: with E0 the first edge sampling a new pattern, output pulses SHALL be visible in the cycle after edge E(STABLE_CYC) (after the 5th edge for default).
REQ-019 Pattern changes shorter than STABLE_CYC+1 edges SHALL produce no accept and no output change.
REQ-020 FSM states S_IDLE (no reference digit) and S_TRACK (reference digit = digit); reset state S_IDLE.
REQ-021 Accept with enable low: no output, counter or state change.
REQ-022 Accepted blank: no pulses, no counter change, state -> S_IDLE, digit holds.
REQ-023 Accepted illegal: illegal pulse, err_cnt +1 (saturating), state -> S_IDLE, digit holds.
REQ-024 Accepted legal d in S_IDLE: digit <= d, digit_valid pulse, state -> S_TRACK, no sequence check.
REQ-025 Accepted legal d in S_TRACK: digit <= d, digit_valid pulse; then exactly one of:
- d == (digit+1) mod M: step_cnt +1
- d == digit: repeat, no count change
- otherwise: seq_err pulse, err_cnt +1
REQ-026 Wrap: digit == M-1 followed by 0 SHALL count as a correct step; digit >= M with any next digit SHALL count as a sequence error unless a repeat.
REQ-027 Pulses (digit_valid, illegal, seq_err) SHALL be registered, one cycle wide, never simultaneously high except digit_valid with seq_err.

Reset
REQ-028 On a rising edge with aclr low: digit=0, all pulses 0, step_cnt=0, err_cnt=0, state S_IDLE, seg_q=1111111, stab_cnt=STABLE_CYC.
REQ-029 Reset mid-filter or mid-accept SHALL abort; no pulse SHALL appear in the cycle after the reset edge.
REQ-030 After reset release, a blank seg held constant SHALL not generate an accept.

Verification (STABLE_CYC=4, M=10 unless noted)
REQ-031 Reset, seg=0000001 for 6 cycles -> digit_valid once after edge E4, digit=0, step_cnt=0, err_cnt=0.
REQ-032 Digits 0..9 then 0, each held 6 cycles -> 11 digit_valid pulses, step_cnt=10, err_cnt=0, seq_err never high.
REQ-033 Digit 3 accepted, seg=1001111 for 2 cycles, back to 3 for 6 -> no accept of 1, one repeat digit_valid, digit=3, step_cnt unchanged, seq_err 0.
REQ-034 Digit 2 accepted, then 5, then 6 -> seq_err with digit=5, err_cnt=1, then step_cnt +1 on 6.
REQ-035 seg=1111110 held 6 cycles -> illegal pulse, err_cnt+1, digit holds; then 7 -> digit_valid, no seq_err, no step.
REQ-036 M=6: 4,5,0 -> step_cnt=2; enable low during a change to 1 -> no pulse, digit stays 0.
